// File: rtl/systolic_skew_feeder_if.sv
// systolic_skew_feeder_if
// Load-side bus of the skew feeder: one beat carries row k of A and column k of B.
//   in_valid : load beat offered (source -> feeder)
//   in_ready : feeder accepts a load beat (feeder -> source)
//   in_a     : row k of A, element j is A[k][j]
//   in_b     : column k of B, element j is B[j][k]
// Modports: master = operand source, slave = feeder.
interface systolic_skew_feeder_if #(
    parameter int DWIDTH = 32,
    parameter int N      = 3
);
    logic                         in_valid;
    logic                         in_ready;
    logic [N-1:0][DWIDTH-1:0]     in_a;
    logic [N-1:0][DWIDTH-1:0]     in_b;

    modport master (output in_valid, output in_a, output in_b, input in_ready);
    modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
// Buffers an NxN operand pair (A row-wise, B column-wise, one beat each) and
// streams it into a systolic array's west/north edges with diagonal skew,
// zero-filling idle lanes, then waits for the array to drain and pulses done.
// Ports:
//   clk, rstn  : clock, synchronous active-low reset
//   load       : systolic_skew_feeder_if.slave (in_valid/in_ready/in_a/in_b)
//   west[r]    : operand for array row r
//   north[c]   : operand for array column c
//   arr_rstn   : active-low reset for the array accumulators
//   busy       : job in progress (CLEAR/STREAM/DRAIN)
//   done       : one-cycle pulse once the array results are final
// Optional feature: define FEEDER_AUTO_CLEAR_EN to insert a one-cycle CLEAR
// state that pulses arr_rstn low before each job's stream.
module systolic_skew_feeder #(
    parameter int DWIDTH = 32,
    parameter int N      = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    systolic_skew_feeder_if.slave    load,
    output logic [N-1:0][DWIDTH-1:0] west,
    output logic [N-1:0][DWIDTH-1:0] north,
    output logic                     arr_rstn,
    output logic                     busy,
    output logic                     done
);
    localparam int CW = $clog2(N);
    localparam int SW = $clog2(2 * N - 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(2 * N - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef FEEDER_AUTO_CLEAR_EN
        S_CLEAR,
`endif
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t state;
    logic [CW-1:0] cnt;    // beat index while loading, drain cycle while draining
    logic [SW-1:0] step;   // stream step currently presented on west/north

    // a_mem[r][k] = A[r][k], b_mem[k][c] = B[k][c]
    logic [N-1:0][N-1:0][DWIDTH-1:0] a_mem;
    logic [N-1:0][N-1:0][DWIDTH-1:0] b_mem;

    logic [N-1:0][DWIDTH-1:0] west_nxt;
    logic [N-1:0][DWIDTH-1:0] north_nxt;
    int unsigned              t_nxt;
    logic                     accept;

    assign load.in_ready = rstn && (state == S_IDLE || state == S_LOAD);
    assign accept        = load.in_valid && load.in_ready;

    // Banks are deliberately not reset; only accepted beats write them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_mem[cnt] <= load.in_a;
            for (int unsigned i = 0; i < N; i++) begin
                b_mem[i][cnt] <= load.in_b[i];
            end
        end
    end

    // Edge values for the step that will be presented next: step+1 while
    // streaming, otherwise step 0 (entering STREAM).
    always_comb begin
        t_nxt     = (state == S_STREAM) ? 32'(step) + 32'd1 : 32'd0;
        west_nxt  = '0;
        north_nxt = '0;
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (r + k == t_nxt) begin
                    west_nxt[r]  = a_mem[r][k];
                    north_nxt[r] = b_mem[k][r];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            step     <= '0;
            west     <= '0;
            north    <= '0;
            arr_rstn <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            arr_rstn <= 1'b1;
            west     <= '0;
            north    <= '0;
            case (state)
                S_IDLE, S_LOAD: begin
                    if (load.in_valid) begin
                        if (cnt == LAST_BEAT) begin
                            cnt  <= '0;
                            busy <= 1'b1;
`ifdef FEEDER_AUTO_CLEAR_EN
                            state    <= S_CLEAR;
                            arr_rstn <= 1'b0;
`else
                            // Step 0 only touches row 0 of A and column 0 of B,
                            // both written by earlier beats (N >= 2), so it can be
                            // registered on the same edge as the final beat.
                            state <= S_STREAM;
                            step  <= '0;
                            west  <= west_nxt;
                            north <= north_nxt;
`endif
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_LOAD;
                        end
                    end
                end
`ifdef FEEDER_AUTO_CLEAR_EN
                S_CLEAR: begin
                    state <= S_STREAM;
                    step  <= '0;
                    west  <= west_nxt;
                    north <= north_nxt;
                end
`endif
                S_STREAM: begin
                    if (step == LAST_STEP) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                    end else begin
                        step  <= step + 1'b1;
                        west  <= west_nxt;
                        north <= north_nxt;
                    end
                end
                S_DRAIN: begin
                    if (cnt == LAST_BEAT) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder
// Drives operand jobs into systolic_skew_feeder, checks skewed edge streams,
// handshake/busy/done/arr_rstn timing each cycle, and the C = A x B results
// of a behavioural systolic array fed by the feeder's outputs.
module tb_systolic_skew_feeder;
    localparam int N  = 3;
    localparam int DW = 32;
`ifdef FEEDER_AUTO_CLEAR_EN
    localparam bit AC = 1'b1;
`else
    localparam bit AC = 1'b0;
`endif
    localparam int S0 = AC ? 2 : 1;        // cycle (after last beat) of step 0
    localparam int L  = S0 + 3 * N - 1;    // cycle of done

    typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;
    typedef struct {
        mat_t a;
        mat_t b;
        int   gap;
        bit   hold;
        mat_t c;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.DWIDTH(DW), .N(N)) lif ();
    logic [N-1:0][DW-1:0] west;
    logic [N-1:0][DW-1:0] north;
    logic arr_rstn, busy, done;

    systolic_skew_feeder #(.DWIDTH(DW), .N(N)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .load     (lif),
        .west     (west),
        .north    (north),
        .arr_rstn (arr_rstn),
        .busy     (busy),
        .done     (done)
    );

    // Behavioural output-stationary systolic array consuming west/north.
    logic [DW-1:0] ha  [N][N];
    logic [DW-1:0] vb  [N][N];
    logic [DW-1:0] acc [N][N];

    function automatic logic [DW-1:0] a_in(int r, int c);
        if (c == 0) return west[r];
        return ha[r][c-1];
    endfunction

    function automatic logic [DW-1:0] b_in(int r, int c);
        if (r == 0) return north[c];
        return vb[r-1][c];
    endfunction

    always @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (!arr_rstn) begin
                    ha[r][c]  <= '0;
                    vb[r][c]  <= '0;
                    acc[r][c] <= '0;
                end else begin
                    ha[r][c]  <= a_in(r, c);
                    vb[r][c]  <= b_in(r, c);
                    acc[r][c] <= acc[r][c] + a_in(r, c) * b_in(r, c);
                end
            end
        end
    end

    int   tests = 0;
    int   fails = 0;
    mat_t exp_acc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic mat_t matmul(mat_t a, mat_t b);
        mat_t m;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                m[r][c] = '0;
                for (int k = 0; k < N; k++) m[r][c] = m[r][c] + a[r][k] * b[k][c];
            end
        return m;
    endfunction

    task automatic drive_beats(input mat_t a, input mat_t b, input int gap, input string tag);
        for (int k = 0; k < N; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    lif.in_valid = 1'b0;
                    @(negedge clk);
                    chk($sformatf("%s gap in_ready", tag), lif.in_ready, 1);
                    chk($sformatf("%s gap busy", tag), busy, 0);
                end
            end
            lif.in_valid = 1'b1;
            for (int j = 0; j < N; j++) begin
                lif.in_a[j] = a[k][j];
                lif.in_b[j] = b[j][k];
            end
            chk($sformatf("%s beat%0d in_ready", tag, k), lif.in_ready, 1);
            @(negedge clk);
        end
    endtask

    // Returns with the bench sitting in the done cycle.
    task automatic run_job(input mat_t a, input mat_t b, input int gap, input bit hold,
                           input mat_t c, input string tag);
        logic [DW-1:0] q[$];
        logic [DW-1:0] ew [N][2*N-1];
        logic [DW-1:0] en [N][2*N-1];
        logic [DW-1:0] ex;
        int t;
        // Expected lanes: lane i is i leading zeros, its N operands, zero pad.
        for (int i = 0; i < N; i++) begin
            q.delete();
            repeat (i) q.push_back('0);
            for (int j = 0; j < N; j++) q.push_back(a[i][j]);
            while (q.size() < 2 * N - 1) q.push_back('0);
            for (int s = 0; s < 2 * N - 1; s++) ew[i][s] = q[s];
            q.delete();
            repeat (i) q.push_back('0);
            for (int j = 0; j < N; j++) q.push_back(b[j][i]);
            while (q.size() < 2 * N - 1) q.push_back('0);
            for (int s = 0; s < 2 * N - 1; s++) en[i][s] = q[s];
        end
        drive_beats(a, b, gap, tag);
        lif.in_valid = hold;
        if (AC) exp_acc = '0;
        for (int r = 0; r < N; r++)
            for (int cc = 0; cc < N; cc++) exp_acc[r][cc] = exp_acc[r][cc] + c[r][cc];
        for (int i = 1; i <= L; i++) begin
            if (hold) begin
                for (int j = 0; j < N; j++) begin
                    lif.in_a[j] = $urandom;
                    lif.in_b[j] = $urandom;
                end
            end
            t = i - S0;
            for (int r = 0; r < N; r++) begin
                ex = (t >= 0 && t <= 2 * N - 2) ? ew[r][t] : '0;
                chk($sformatf("%s c%0d west[%0d]", tag, i, r), west[r], ex);
                ex = (t >= 0 && t <= 2 * N - 2) ? en[r][t] : '0;
                chk($sformatf("%s c%0d north[%0d]", tag, i, r), north[r], ex);
            end
            chk($sformatf("%s c%0d busy", tag, i), busy, i < L);
            chk($sformatf("%s c%0d done", tag, i), done, i == L);
            chk($sformatf("%s c%0d in_ready", tag, i), lif.in_ready, i == L);
            chk($sformatf("%s c%0d arr_rstn", tag, i), arr_rstn, !(AC && i == 1));
            if (i == L) begin
                for (int r = 0; r < N; r++)
                    for (int cc = 0; cc < N; cc++)
                        chk($sformatf("%s results[%0d][%0d]", tag, r, cc), acc[r][cc], exp_acc[r][cc]);
            end
            if (i == L - 1) lif.in_valid = 1'b0;
            if (i < L) @(negedge clk);
        end
    endtask

    task automatic reset_mid_stream(input mat_t a, input mat_t b);
        drive_beats(a, b, 0, "rst");
        lif.in_valid = 1'b0;
        repeat (S0 + 1) @(negedge clk);
        chk("rst step2 west[1]", west[1], a[1][1]);
        rstn = 1'b0;
        @(negedge clk);
        for (int r = 0; r < N; r++) begin
            chk($sformatf("rst west[%0d]", r), west[r], 0);
            chk($sformatf("rst north[%0d]", r), north[r], 0);
        end
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst in_ready", lif.in_ready, 0);
        chk("rst arr_rstn", arr_rstn, 0);
        rstn = 1'b1;
        exp_acc = '0;
        for (int i = 0; i < 3 * N + 2; i++) begin
            @(negedge clk);
            chk($sformatf("post-rst c%0d done", i), done, 0);
            chk($sformatf("post-rst c%0d busy", i), busy, 0);
            chk($sformatf("post-rst c%0d in_ready", i), lif.in_ready, 1);
            chk($sformatf("post-rst c%0d arr_rstn", i), arr_rstn, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        mat_t ma, mb, ident;
        int   c0[9];
        int   gap;
        bit   hold;
        c0 = '{84, 90, 96, 201, 216, 231, 318, 342, 366};
        ident = '0;
        for (int r = 0; r < N; r++) begin
            ident[r][r] = 1;
            for (int c = 0; c < N; c++) begin
                ma[r][c] = DW'(r * N + c + 1);
                mb[r][c] = DW'(r * N + c + 10);
            end
        end
        vecs[0].a = ma;    vecs[0].b = mb; vecs[0].gap = 0; vecs[0].hold = 0;
        vecs[1].a = ident; vecs[1].b = mb; vecs[1].gap = 0; vecs[1].hold = 0;
        vecs[2].a = ma;    vecs[2].b = mb; vecs[2].gap = 2; vecs[2].hold = 0;
        vecs[3].a = ma;    vecs[3].b = mb; vecs[3].gap = 1; vecs[3].hold = 1;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                vecs[0].c[r][c] = DW'(c0[r * N + c]);
                vecs[1].c[r][c] = DW'(r * N + c + 10);
                vecs[2].c[r][c] = DW'(c0[r * N + c]);
                vecs[3].c[r][c] = DW'(c0[r * N + c]);
            end

        rstn = 1'b0;
        lif.in_valid = 1'b0;
        lif.in_a = '0;
        lif.in_b = '0;
        repeat (2) @(negedge clk);
        for (int r = 0; r < N; r++) begin
            chk($sformatf("reset west[%0d]", r), west[r], 0);
            chk($sformatf("reset north[%0d]", r), north[r], 0);
        end
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset in_ready", lif.in_ready, 0);
        chk("reset arr_rstn", arr_rstn, 0);
        rstn = 1'b1;
        exp_acc = '0;
        @(negedge clk);
        chk("post-reset in_ready", lif.in_ready, 1);
        chk("post-reset arr_rstn", arr_rstn, 1);

        for (int v = 0; v < 4; v++)
            run_job(vecs[v].a, vecs[v].b, vecs[v].gap, vecs[v].hold, vecs[v].c,
                    $sformatf("vec%0d", v));

        reset_mid_stream(ma, mb);
        run_job(ma, mb, 0, 1'b0, vecs[0].c, "reload");

        for (int j = 0; j < 4; j++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    ma[r][c] = DW'($urandom_range(0, 1000));
                    mb[r][c] = DW'($urandom_range(0, 1000));
                end
            gap  = int'($urandom_range(0, 2));
            hold = 1'($urandom_range(0, 1));
            run_job(ma, mb, gap, hold, matmul(ma, mb), $sformatf("rand%0d", j));
        end

        repeat (3) @(negedge clk);
        chk("final idle done", done, 0);
        chk("final idle busy", busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream feeder for `systolic_array`. It accepts an N×N operand pair A and B one beat at a time, buffers both matrices, and drives the array's `west`/`north` edges with the diagonal skew the array needs. Cycles with no operand are zero-filled, so idle PEs accumulate 0. It optionally clears the array's accumulators before each job, and pulses `done` once the array's `results` hold the finished C = A×B.

## Interface
- `DWIDTH`, 32: operand width; matches the array.
- `N`, 3: array dimension; ≥2.
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: synchronous, active-low reset.
- `in_valid` input 1: load beat offered.
- `in_ready` output 1: feeder accepts a load beat.
- `in_a` input [N][DWIDTH]: row k of A on beat k.
- `in_b` input [N][DWIDTH]: column k of B on beat k.
- `west` output [N][DWIDTH]: to array `west`; element r is row r.
- `north` output [N][DWIDTH]: to array `north`; element c is column c.
- `arr_rstn` output 1: drives the array's `rstn`; active-low.
- `busy` output 1: a job is in progress (CLEAR/STREAM/DRAIN).
- `done` output 1: one-cycle pulse when `results` are final.

## Operation
- Storage: two N×N register banks, `a_mem[r][k]` and `b_mem[k][c]`.
- Beat k writes `a_mem[k][*]=in_a` and `b_mem[*][k]=in_b`.
- Beat counter runs 0..N-1.
- States:
  - IDLE: `in_ready`=1.
  - LOAD: `in_ready`=1.
  - CLEAR: present only with `FEEDER_AUTO_CLEAR_EN`.
  - STREAM.
  - DRAIN.
- Transitions:
  - IDLE→LOAD on the first beat, or straight to the next state if N beats complete.
  - LOAD→CLEAR (or →STREAM without the macro) on beat N-1.
  - CLEAR→STREAM after 1 cycle.
  - STREAM→DRAIN after 2N-1 steps.
  - DRAIN→IDLE after N cycles; `done`=1 in the first IDLE cycle.
- Skew at stream step t (0..2N-2):
  - `west[r] = a_mem[r][t-r]` if 0 ≤ t-r < N, else 0.
  - `north[c] = b_mem[t-c][c]` if 0 ≤ t-c < N, else 0.
- In every non-STREAM state, `west` and `north` are all zeros.
- DRAIN length N covers N-1 hops for the last operand to reach PE(N-1,N-1), plus 1 accumulate cycle. This relies on the array registering one hop per cycle.
- `in_valid` gaps during LOAD are allowed; counter and state hold.
- `in_valid` outside IDLE/LOAD is ignored; `in_ready`=0 there.
- Reset at any point: state→IDLE, banks are not cleared, beat counter→0, job aborted, no `done`.
- Reset values (cycle after an edge with `rstn`=0): `west`/`north`=0, `arr_rstn`=0, `busy`=0, `done`=0, `in_ready`=0 while `rstn` is low.
- After reset: `in_ready`=1, `arr_rstn`=1.

## Timing
- All outputs except `in_ready` are flops. `in_ready` decodes the state register.
- Cycle reference: final load beat accepted at edge T.
- With `FEEDER_AUTO_CLEAR_EN`:
  - CLEAR in cycle T+1: `arr_rstn`=0, edges zero.
  - Step t in cycle T+2+t.
  - DRAIN in cycles T+2N+1..T+3N.
  - `done` in cycle T+3N+1; `in_ready` is 1 in that same cycle.
- Without the macro, every figure shifts 1 earlier: step t in T+1+t, `done` in T+3N.
- Latency from last beat to `done` is 3N+1 with the macro, 3N without (10 / 9 for N=3).
- A new load beat is accepted in the `done` cycle. Back-to-back jobs have no bubble beyond that.
- `busy`=1 from cycle T+1 through the last DRAIN cycle.

## Configuration
- `FEEDER_AUTO_CLEAR_EN` defined:
  - CLEAR state exists.
  - `arr_rstn` is driven low for exactly one cycle per job and during reset.
- Undefined:
  - No CLEAR state.
  - `arr_rstn` is a flop of `rstn`, so accumulators persist across jobs and the integrator clears the array.

## Test plan
- Macro on, N=3, A=1..9 row-major, B=10..18 row-major, 3 consecutive beats:
  - `west[1]` per step = 0,4,5,6,0; `north[2]` = 0,0,12,15,18.
  - At `done`, `results` = 84,90,96,201,216,231,318,342,366.
  - `done` lands exactly 10 cycles after the last beat.
- Same job with `in_valid` deasserted 2 cycles between each beat: identical skewed streams; `done` lands 10 cycles after the last beat.
- Two back-to-back jobs, second with A=identity, B=10..18, macro on:
  - `arr_rstn` pulses low once per job.
  - Second `results` = 10..18.
- Macro off, same two jobs:
  - `arr_rstn` stays 1.
  - Second `results` = first C + B (e.g. `results[0]`=94).
  - `done` lands 9 cycles after the last beat.
- `in_valid` held high during STREAM: `in_ready`=0, no bank writes, output streams unchanged.
- `rstn` low for 1 cycle at stream step 2:
  - Outputs go to 0, `busy`=0, no `done`.
  - After reset, `in_ready`=1 and a full reload completes correctly.
